// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//
// Memory-stage responder for the pipeline's load/store requests. One 32-bit
// access is split into two 16-bit accesses on an external asynchronous SRAM,
// low half-word first, then high half-word. ready is held low while an access
// is in flight so the hazard/freeze logic stalls the whole pipeline.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset; aborts any access in flight
//   MEM_r_en     load request, held stable by the pipeline while ready=0
//   MEM_w_en     store request, held stable by the pipeline while ready=0
//   address      byte address from the ALU result
//   write_data   store data
//   read_data    load result, valid in the cycle where ready=1 ends a read
//   ready        0 = freeze pipeline; 1 = idle, or access completing
//   sram_addr    SRAM half-word address
//   sram_dq_out  write data for the SRAM data bus
//   sram_dq_oe   1 = drive sram_dq_out onto the SRAM data bus
//   sram_dq_in   SRAM data bus input
//   sram_we_n    active-low SRAM write strobe
// -----------------------------------------------------------------------------
module sram_mem_controller #(
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 5      // clocks per half-word access, >= 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   MEM_r_en,
    input  logic                   MEM_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n
);

    localparam int                CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [SRAM_ADDR_W-2:0]  word_q;
    logic [31:0]             data_q;
    logic                    is_write;

    logic                    request;
    logic [31:0]             offset;
    logic [SRAM_ADDR_W-2:0]  word;
    logic                    last_cycle;
    logic                    in_phase;
    logic                    unused_offset_bits;

    assign request    = MEM_r_en | MEM_w_en;

    // Word index of the access; bits above the SRAM range simply wrap away.
    assign offset     = address - 32'(ADDR_BASE);
    assign word       = offset[SRAM_ADDR_W:2];
    assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

    assign last_cycle = (cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // State register, counter and access latches
    // -------------------------------------------------------------------------
    // NOTE: every register here uses <= so all of them see pre-edge values;
    // blocking assignments would make ordering inside the block matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            word_q    <= '0;
            data_q    <= '0;
            is_write  <= 1'b0;
            read_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;

            // Address, data and direction are frozen for the whole access so
            // later changes on the request inputs cannot corrupt it.
            if (state == IDLE && request) begin
                word_q   <= word;
                data_q   <= write_data;
                is_write <= MEM_w_en;     // a write wins when both are high
            end

            // The SRAM output has had the full phase to settle by its last cycle.
            if (!is_write && last_cycle) begin
                if (state == LOW)  read_data[15:0]  <= sram_dq_in;
                if (state == HIGH) read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        in_phase    = (state == LOW) || (state == HIGH);
        ready       = 1'b0;
        sram_addr   = {word_q, (state == HIGH)};
        sram_dq_oe  = in_phase && is_write;
        // WE rises one cycle before the phase ends so data and address are
        // still held across the SRAM's write-latching edge.
        sram_we_n   = !(in_phase && is_write && !last_cycle);
        sram_dq_out = '0;

        if (sram_dq_oe) begin
            sram_dq_out = (state == HIGH) ? data_q[31:16] : data_q[15:0];
        end

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                ready    = !request;     // low in the very cycle a request appears
                if (request) state_next = LOW;
            end
            LOW: begin
                if (last_cycle) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (last_cycle) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                ready      = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Directed bench for sram_mem_controller with a small asynchronous SRAM model.
// A table of per-cycle vectors covers reset, a load, a store and an idle
// stretch; hand-written sequences cover back-to-back accesses, simultaneous
// read/write requests and a reset during an access.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

    localparam int AW = 18;

    logic          clk;
    logic          rst_n;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    int tests_run;
    int tests_failed;

    sram_mem_controller #(
        .ADDR_BASE   (1024),
        .SRAM_ADDR_W (AW),
        .WAIT_CYCLES (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MEM_r_en    (mem_r_en),
        .MEM_w_en    (mem_w_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM model: combinational read, write latched on the WE rising edge.
    logic [15:0] mem [0:255];
    assign sram_dq_in = mem[sram_addr[7:0]];
    always @(posedge sram_we_n) begin
        if (sram_dq_oe) mem[sram_addr[7:0]] = sram_dq_out;
    end

    // -------------------------------------------------------------------------
    // Per-cycle vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ready;
        logic        exp_we_n;
        logic        exp_oe;
        bit          chk_addr;
        logic [AW-1:0] exp_addr;
        bit          chk_dq;
        logic [15:0] exp_dq;
        bit          chk_rd;
        logic [31:0] exp_rd;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_ready, input logic e_we_n, input logic e_oe,
                       input bit c_addr, input logic [AW-1:0] e_addr,
                       input bit c_dq, input logic [15:0] e_dq,
                       input bit c_rd, input logic [31:0] e_rd);
        vec_t v;
        v.tag = tag; v.r = r; v.w = w; v.addr = addr; v.wdata = wdata;
        v.exp_ready = e_ready; v.exp_we_n = e_we_n; v.exp_oe = e_oe;
        v.chk_addr = c_addr; v.exp_addr = e_addr;
        v.chk_dq = c_dq; v.exp_dq = e_dq;
        v.chk_rd = c_rd; v.exp_rd = e_rd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge and drive the request inputs.
    task automatic drive(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(posedge clk);
        #1;
        mem_r_en   = r;
        mem_w_en   = w;
        address    = addr;
        write_data = wdata;
    endtask

    int we_low;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[4] = 16'h1234;
        mem[5] = 16'hABCD;

        // ---- table: load at 1032, store at 1032, 20 idle cycles --------------
        add("ld c0", 1, 0, 32'd1032, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 5; c++)
            add($sformatf("ld c%0d", c), 1, 0, 32'd1032, 0, 0, 1, 0, 1, 18'd4, 0, 0, 0, 0);
        add("ld c6", 1, 0, 32'd1032, 0, 0, 1, 0, 1, 18'd5, 0, 0, 1, 32'h0000_1234);
        for (int c = 7; c <= 10; c++)
            add($sformatf("ld c%0d", c), 1, 0, 32'd1032, 0, 0, 1, 0, 1, 18'd5, 0, 0, 0, 0);
        add("ld c11", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'hABCD_1234);
        add("ld c12", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'hABCD_1234);

        add("st c0", 0, 1, 32'd1032, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++)
            add($sformatf("st c%0d", c), 0, 1, 32'd1032, 32'hDEAD_BEEF, 0, 0, 1, 1, 18'd4, 1, 16'hBEEF, 0, 0);
        add("st c5", 0, 1, 32'd1032, 32'hDEAD_BEEF, 0, 1, 1, 1, 18'd4, 1, 16'hBEEF, 0, 0);
        for (int c = 6; c <= 9; c++)
            add($sformatf("st c%0d", c), 0, 1, 32'd1032, 32'hDEAD_BEEF, 0, 0, 1, 1, 18'd5, 1, 16'hDEAD, 0, 0);
        add("st c10", 0, 1, 32'd1032, 32'hDEAD_BEEF, 0, 1, 1, 1, 18'd5, 1, 16'hDEAD, 0, 0);
        add("st c11", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'hABCD_1234);
        add("st c12", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'hABCD_1234);

        for (int c = 0; c < 20; c++)
            add($sformatf("idle c%0d", c), 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // ---- reset values -----------------------------------------------------
        rst_n = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        address = '0; write_data = '0;
        #12;
        check("rst read_data", read_data, 32'h0);
        check("rst sram_addr", 32'(sram_addr), 32'h0);
        check("rst dq_out",    32'(sram_dq_out), 32'h0);
        check("rst dq_oe",     32'(sram_dq_oe), 32'h0);
        check("rst we_n",      32'(sram_we_n), 32'h1);
        check("rst ready",     32'(ready), 32'h1);
        rst_n = 1'b1;

        // ---- table replay ------------------------------------------------------
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata);
            #3;
            check({vecs[i].tag, " ready"}, 32'(ready), 32'(vecs[i].exp_ready));
            check({vecs[i].tag, " we_n"},  32'(sram_we_n), 32'(vecs[i].exp_we_n));
            check({vecs[i].tag, " oe"},    32'(sram_dq_oe), 32'(vecs[i].exp_oe));
            if (vecs[i].chk_addr) check({vecs[i].tag, " addr"}, 32'(sram_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].chk_dq)   check({vecs[i].tag, " dq"},   32'(sram_dq_out), 32'(vecs[i].exp_dq));
            if (vecs[i].chk_rd)   check({vecs[i].tag, " rd"},   read_data, vecs[i].exp_rd);
        end
        check("mem[4] after store", 32'(mem[4]), 32'h0000_BEEF);
        check("mem[5] after store", 32'(mem[5]), 32'h0000_DEAD);

        // ---- back-to-back store then load at 1040 (half-words 8/9) ----------
        for (int c = 0; c <= 10; c++) drive(0, 1, 32'd1040, 32'h0BAD_F00D);
        drive(1, 0, 32'd1040, 32'h0);                 // cycle 11: DONE of store
        #3;
        check("b2b store done ready", 32'(ready), 32'h1);
        drive(1, 0, 32'd1040, 32'h0);                 // cycle 12: load seen
        #3;
        check("b2b load start ready", 32'(ready), 32'h0);
        for (int c = 13; c <= 22; c++) drive(1, 0, 32'd1040, 32'h0);
        #3;
        check("b2b load busy ready", 32'(ready), 32'h0);
        drive(0, 0, 32'h0, 32'h0);                    // cycle 23: DONE of load
        #3;
        check("b2b load done ready", 32'(ready), 32'h1);
        check("b2b load data", read_data, 32'h0BAD_F00D);

        // ---- both requests high at 1048: must write, read_data untouched -----
        we_low = 0;
        for (int c = 0; c <= 10; c++) begin
            drive(1, 1, 32'd1048, 32'h5555_AAAA);
            #3;
            if (sram_we_n == 1'b0) we_low++;
        end
        drive(0, 0, 32'h0, 32'h0);
        #3;
        check("both done ready", 32'(ready), 32'h1);
        check("both we_n low cycles", 32'(we_low), 32'd8);
        check("both read_data kept", read_data, 32'h0BAD_F00D);
        check("both mem[12]", 32'(mem[12]), 32'h0000_AAAA);
        check("both mem[13]", 32'(mem[13]), 32'h0000_5555);

        // ---- reset during HIGH phase of a store at 1056 ----------------------
        for (int c = 0; c <= 7; c++) drive(0, 1, 32'd1056, 32'h1111_2222);
        #1;
        check("pre-rst in HIGH addr", 32'(sram_addr), 32'd17);
        rst_n = 1'b0;
        mem_w_en = 1'b0;
        #1;
        check("mid-rst read_data", read_data, 32'h0);
        check("mid-rst sram_addr", 32'(sram_addr), 32'h0);
        check("mid-rst dq_out",    32'(sram_dq_out), 32'h0);
        check("mid-rst dq_oe",     32'(sram_dq_oe), 32'h0);
        check("mid-rst we_n",      32'(sram_we_n), 32'h1);
        check("mid-rst ready",     32'(ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 32'h0);
        #3;
        check("post-rst ready", 32'(ready), 32'h1);
        check("post-rst we_n",  32'(sram_we_n), 32'h1);
        drive(0, 0, 32'h0, 32'h0);
        #3;
        check("post-rst ready 2", 32'(ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
